cdb_arbiter: RTL

Writeback stage that drains the ALU, branch and memory functional-unit results onto a single common data bus (CDB) feeding the PRF write port, the reservation-station wakeup logic and the ROB completion logic. Each FU result lands in a small per-FU queue. Every cycle the oldest surviving head, by ROB age, is broadcast. Entries younger than a branch mispredict are squashed, and queue occupancy back-pressures the FUs.

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_arbiter_if.sv | 40 ++++
 rtl/cdb_arbiter_fifo.sv | 71 +++++++
 rtl/cdb_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter shared types: writeback entry, FU indices, tag age helper.
// Ages are measured from the ROB head, modulo the tag space.
package cdb_arbiter_pkg;

  localparam int ROB_W = 5;

  localparam int FU_ALU = 0;
  localparam int FU_B = 1;
  localparam int FU_MEM = 2;
  localparam int NUM_FU = 3;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob_tag;
    logic [6:0]       pd;
    logic [31:0]      data;
    logic             wr_en;
  } wb_entry;

  function automatic logic [ROB_W-1:0] tag_age(
    input logic [ROB_W-1:0] tag,
    input logic [ROB_W-1:0] head
  );
    return tag - head;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter bus bundle: FU results and flush in, CDB and status out.
// master drives the FU side, slave is the arbiter.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  wb_entry          alu_in;
  wb_entry          b_in;
  wb_entry          mem_in;
  logic [ROB_W-1:0] rob_head;
  logic             mispredict;
  logic [ROB_W-1:0] mispredict_tag;
  logic [2:0]       fu_stall;
  wb_entry          cdb_out;
  logic             overflow_err;

  modport master (
    output alu_in,
    output b_in,
    output mem_in,
    output rob_head,
    output mispredict,
    output mispredict_tag,
    input  fu_stall,
    input  cdb_out,
    input  overflow_err
  );

  modport slave (
    input  alu_in,
    input  b_in,
    input  mem_in,
    input  rob_head,
    input  mispredict,
    input  mispredict_tag,
    output fu_stall,
    output cdb_out,
    output overflow_err
  );

endinterface

// File: rtl/cdb_arbiter_fifo.sv
// wb_fifo: per-FU result queue with per-slot kill bits for flush squashing.
// Pushes are pre-qualified by the arbiter; killed heads drain via pop.
module wb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry          push_entry,
  input  logic             pop,
  input  logic             flush,
  input  logic [ROB_W-1:0] flush_age,
  input  logic [ROB_W-1:0] rob_head,
  output wb_entry          head,
  output logic             head_live,
  output logic             head_killed,
  output logic             full,
  output logic             almost_full
);

  localparam int PW = $clog2(DEPTH);

  wb_entry          mem [DEPTH];
  logic [DEPTH-1:0] kill;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             occupied;
  logic             do_pop;

  assign occupied = count != '0;
  assign do_pop = pop && occupied;
  assign head = mem[rd_ptr];
  assign head_killed = occupied && kill[rd_ptr];
  assign head_live = occupied && !kill[rd_ptr];
  assign full = count == (PW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      almost_full <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush && tag_age(mem[i].rob_tag, rob_head) > flush_age)
          kill[i] <= 1'b1;
      end
      // new entries already passed the flush filter
      if (push) begin
        kill[wr_ptr] <= 1'b0;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      almost_full <= count >= (PW+1)'(DEPTH-1);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: drains ALU/branch/mem results onto the single CDB.
// Oldest live head by ROB age wins; mispredicts squash younger work.
module cdb_arbiter #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 5
) (
  input logic          clk,
  input logic          reset,
  cdb_arbiter_if.slave bus
);
  import cdb_arbiter_pkg::*;

  wb_entry          in_e [NUM_FU];
  wb_entry          head [NUM_FU];
  logic [ROB_W-1:0] age [NUM_FU];
  logic [2:0]       live;
  logic [2:0]       killed;
  logic [2:0]       full;
  logic [2:0]       afull;
  logic [2:0]       young;
  logic [2:0]       push;
  logic [2:0]       drop;
  logic [2:0]       win;
  logic [2:0]       pop;
  logic [ROB_W-1:0] flush_age;
  logic [ROB_W-1:0] win_age;
  wb_entry          win_e;
  wb_entry          cdb_q;
  logic             bcast;
  logic             ovf_q;

  assign in_e[FU_ALU] = bus.alu_in;
  assign in_e[FU_B] = bus.b_in;
  assign in_e[FU_MEM] = bus.mem_in;
  assign flush_age =
    tag_age(bus.mispredict_tag, bus.rob_head);

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign age[g] = tag_age(head[g].rob_tag, bus.rob_head);
    assign young[g] = bus.mispredict &&
      tag_age(in_e[g].rob_tag, bus.rob_head) > flush_age;
    assign pop[g] = win[g] | killed[g];
    assign push[g] = in_e[g].valid && !young[g] &&
      (!full[g] || pop[g]);
    assign drop[g] = in_e[g].valid && !young[g] &&
      full[g] && !pop[g];

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push[g]),
      .push_entry  (in_e[g]),
      .pop         (pop[g]),
      .flush       (bus.mispredict),
      .flush_age   (flush_age),
      .rob_head    (bus.rob_head),
      .head        (head[g]),
      .head_live   (live[g]),
      .head_killed (killed[g]),
      .full        (full[g]),
      .almost_full (afull[g])
    );
  end

  // live ROB tags are unique, so at most one head can win
  assign win[FU_ALU] = live[FU_ALU] &&
    (!live[FU_B] || age[FU_ALU] < age[FU_B]) &&
    (!live[FU_MEM] || age[FU_ALU] < age[FU_MEM]);
  assign win[FU_B] = live[FU_B] &&
    (!live[FU_ALU] || age[FU_B] < age[FU_ALU]) &&
    (!live[FU_MEM] || age[FU_B] < age[FU_MEM]);
  assign win[FU_MEM] = live[FU_MEM] &&
    (!live[FU_ALU] || age[FU_MEM] < age[FU_ALU]) &&
    (!live[FU_B] || age[FU_MEM] < age[FU_B]);

  always_comb begin
    win_e = '0;
    unique case (1'b1)
      win[FU_ALU]: win_e = head[FU_ALU];
      win[FU_B]:   win_e = head[FU_B];
      win[FU_MEM]: win_e = head[FU_MEM];
      default:     win_e = '0;
    endcase
  end

  assign win_age = tag_age(win_e.rob_tag, bus.rob_head);
  assign bcast = (|win) &&
    !(bus.mispredict && win_age > flush_age);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cdb_q.valid <= bcast;
      if (bcast) begin
        cdb_q <= win_e;
        cdb_q.valid <= 1'b1;
      end
      if (|drop) ovf_q <= 1'b1;
    end
  end

  assign bus.cdb_out = cdb_q;
  assign bus.fu_stall = afull;
  assign bus.overflow_err = ovf_q;

endmodule
